// File: rtl/consmax_pkg.sv
// consmax_pkg: shared widths and types for the multi-head ConSmax unit.
// LUT geometry is fixed here; the 8-bit score is split into two 4-bit
// LUT addresses, so LUT_ADDR must stay at half the byte width.
package consmax_pkg;
    localparam int LUT_ADDR  = 4;
    localparam int LUT_DATA  = 16;
    localparam int SHIFT_BIT = 5;
    localparam int LUT_N     = 1 << LUT_ADDR;
    localparam int BEAT_W    = 64;

    typedef logic [LUT_DATA-1:0]   lut_entry_t;
    typedef logic [2*LUT_DATA-1:0] product_t;
    typedef logic [BEAT_W-1:0]     head_beat_t;
    typedef lut_entry_t [LUT_N-1:0] lut_tab_t;

    typedef struct packed {
        logic                sel;
        logic [LUT_ADDR-1:0] addr;
        lut_entry_t          data;
    } lut_wr_t;
endpackage

// File: rtl/consmax_if.sv
// consmax_if: per-head valid/ready beat bus. Head h occupies element [h]
// of each packed array, i.e. bits [h*GBUS_DATA +: GBUS_DATA] when flattened.
interface consmax_if #(
    parameter int HNUM      = 8,
    parameter int GBUS_DATA = 64
);
    logic [HNUM-1:0][GBUS_DATA-1:0] in_data;
    logic [HNUM-1:0]                in_valid;
    logic [HNUM-1:0]                in_ready;
    logic [HNUM-1:0][GBUS_DATA-1:0] out_data;
    logic [HNUM-1:0]                out_valid;
    logic [HNUM-1:0]                out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/consmax_head_pipe.sv
// consmax_head_pipe: one head's 3-stage exp pipeline.
//   S0 latches both LUT reads per byte, S1 multiplies, S2 shifts/saturates.
// Each stage loads when empty or when its content moves on, so bubbles
// collapse and in_ready is combinational from out_ready.
// Optional macro CONSMAX_SAT_CNT_EN adds a sticky saturation counter.
module consmax_head_pipe
    import consmax_pkg::*;
#(
    parameter int GBUS_DATA = BEAT_W
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [SHIFT_BIT-1:0] cfg_shift,
    input  lut_tab_t             lut_hi,
    input  lut_tab_t             lut_lo,
    input  logic [GBUS_DATA-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [GBUS_DATA-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef CONSMAX_SAT_CNT_EN
    ,
    output logic [15:0]          sat_cnt,
    input  logic                 sat_cnt_clr
`endif
);
    localparam int BYTES = GBUS_DATA / 8;

    logic [2:0]             vld_pipe;
    logic                   ld0, ld1, ld2;
    lut_entry_t [BYTES-1:0] hi_d, lo_d, hi_q, lo_q;
    product_t   [BYTES-1:0] prod_d, prod_q, shf;
    logic [BYTES-1:0][7:0]  res_d;
    logic [BYTES-1:0]       sat_d;

    assign ld2       = !vld_pipe[2] | out_ready;
    assign ld1       = !vld_pipe[1] | ld2;
    assign ld0       = !vld_pipe[0] | ld1;
    assign in_ready  = ld0;
    assign out_valid = vld_pipe[2];

    for (genvar b = 0; b < BYTES; b++) begin : g_byte
        assign hi_d[b]   = lut_hi[in_data[b*8+4 +: LUT_ADDR]];
        assign lo_d[b]   = lut_lo[in_data[b*8 +: LUT_ADDR]];
        assign prod_d[b] = hi_q[b] * lo_q[b];
        assign shf[b]    = prod_q[b] >> cfg_shift;
        assign sat_d[b]  = |shf[b][2*LUT_DATA-1:8];
        assign res_d[b]  = sat_d[b] ? 8'hFF : shf[b][7:0];
    end

    // Stage occupancy: each valid bit advances only when its stage loads
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe <= '0;
        end else begin
            if (ld0) vld_pipe[0] <= in_valid;
            if (ld1) vld_pipe[1] <= vld_pipe[0];
            if (ld2) vld_pipe[2] <= vld_pipe[1];
        end
    end

    // Datapath captures only real beats, so out_data holds through stalls
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hi_q     <= '0;
            lo_q     <= '0;
            prod_q   <= '0;
            out_data <= '0;
        end else begin
            if (ld0 && in_valid) begin
                hi_q <= hi_d;
                lo_q <= lo_d;
            end
            if (ld1 && vld_pipe[0]) prod_q   <= prod_d;
            if (ld2 && vld_pipe[1]) out_data <= res_d;
        end
    end

`ifdef CONSMAX_SAT_CNT_EN
    localparam int PW = $clog2(BYTES + 1);

    logic [BYTES-1:0] sat_q;
    logic [PW-1:0]    sat_num;
    logic [16:0]      cnt_sum;

    // Number of saturated bytes in the beat sitting at the output
    always_comb begin
        sat_num = '0;
        for (int b = 0; b < BYTES; b++) sat_num = sat_num + PW'(sat_q[b]);
    end

    assign cnt_sum = {1'b0, sat_cnt} + 17'(sat_num);

    // Saturation mask rides with out_data; clear beats increment, count sticks at max
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sat_q   <= '0;
            sat_cnt <= '0;
        end else begin
            if (ld2 && vld_pipe[1]) sat_q <= sat_d;
            if (sat_cnt_clr)
                sat_cnt <= '0;
            else if (out_valid && out_ready)
                sat_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        end
    end
`endif
endmodule

// File: rtl/consmax_array.sv
// consmax_array: HNUM independent ConSmax head pipelines sharing one
// runtime-programmable split exponent LUT pair (LUT_HI, LUT_LO).
// Optional macro CONSMAX_SAT_CNT_EN exposes per-head saturation counters.
module consmax_array
    import consmax_pkg::*;
#(
    parameter int HNUM      = 8,
    parameter int GBUS_DATA = BEAT_W
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [SHIFT_BIT-1:0] cfg_shift,
    input  logic                 lut_wen,
    input  logic                 lut_sel,
    input  logic [LUT_ADDR-1:0]  lut_waddr,
    input  lut_entry_t           lut_wdata,
    consmax_if.slave             bus
`ifdef CONSMAX_SAT_CNT_EN
    ,
    output logic [HNUM-1:0][15:0] sat_cnt,
    input  logic                  sat_cnt_clr
`endif
);
    lut_tab_t lut_hi, lut_lo;
    lut_wr_t  wr;

    logic [HNUM-1:0]                rdy, ovld;
    logic [HNUM-1:0][GBUS_DATA-1:0] odat;

    assign wr = '{sel: lut_sel, addr: lut_waddr, data: lut_wdata};

    // Shared LUT write port; a same-cycle lookup still sees the old entry
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lut_hi <= '0;
            lut_lo <= '0;
        end else if (lut_wen) begin
            if (wr.sel) lut_lo[wr.addr] <= wr.data;
            else        lut_hi[wr.addr] <= wr.data;
        end
    end

    for (genvar h = 0; h < HNUM; h++) begin : g_head
        consmax_head_pipe #(.GBUS_DATA(GBUS_DATA)) u_pipe (
            .clk         (clk),
            .rstn        (rstn),
            .cfg_shift   (cfg_shift),
            .lut_hi      (lut_hi),
            .lut_lo      (lut_lo),
            .in_data     (bus.in_data[h]),
            .in_valid    (bus.in_valid[h]),
            .in_ready    (rdy[h]),
            .out_data    (odat[h]),
            .out_valid   (ovld[h]),
            .out_ready   (bus.out_ready[h])
`ifdef CONSMAX_SAT_CNT_EN
            ,
            .sat_cnt     (sat_cnt[h]),
            .sat_cnt_clr (sat_cnt_clr)
`endif
        );
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = ovld;
    assign bus.out_data  = odat;
endmodule

// File: tb/tb_consmax_array.sv
// tb_consmax_array: directed + randomized checks of consmax_array against
// a queue-based reference that evaluates exp bytes with plain arithmetic.
module tb_consmax_array;
    import consmax_pkg::*;

    localparam int HNUM = 8;
    localparam int GW   = 64;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [SHIFT_BIT-1:0] cfg_shift;
    logic                 lut_wen, lut_sel;
    logic [LUT_ADDR-1:0]  lut_waddr;
    logic [LUT_DATA-1:0]  lut_wdata;
`ifdef CONSMAX_SAT_CNT_EN
    logic [HNUM-1:0][15:0] sat_cnt;
    logic                  sat_cnt_clr;
`endif

    consmax_if #(.HNUM(HNUM), .GBUS_DATA(GW)) bus ();

    consmax_array #(.HNUM(HNUM), .GBUS_DATA(GW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cfg_shift  (cfg_shift),
        .lut_wen    (lut_wen),
        .lut_sel    (lut_sel),
        .lut_waddr  (lut_waddr),
        .lut_wdata  (lut_wdata),
        .bus        (bus)
`ifdef CONSMAX_SAT_CNT_EN
        ,
        .sat_cnt    (sat_cnt),
        .sat_cnt_clr(sat_cnt_clr)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int m_hi [16];
    int m_lo [16];
    logic [63:0] expq [HNUM][$];
    logic [63:0] got  [HNUM][$];
    int acc_cnt [HNUM];

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: exp byte = min((HI[x>>4] * LO[x&15]) >> shift, 255)
    function automatic logic [63:0] model_beat(input logic [63:0] d);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) begin
            longint p, q;
            p = longint'(m_hi[d[b*8+4 +: 4]]) * longint'(m_lo[d[b*8 +: 4]]);
            q = p >>> cfg_shift;
            r[b*8 +: 8] = (q > 255) ? 8'hFF : q[7:0];
        end
        return r;
    endfunction

    // One clock: score handshakes seen just before the edge, then the LUT write
    task automatic cyc();
        logic [63:0] e;
        #1;
        for (int h = 0; h < HNUM; h++) begin
            if (bus.out_valid[h] && bus.out_ready[h]) begin
                n_cmp++;
                assert (expq[h].size() > 0) else begin
                    n_err++;
                    $error("FAIL sb_extra head %0d: observed beat %h expected none", h, bus.out_data[h]);
                end
                if (expq[h].size() > 0) begin
                    e = expq[h].pop_front();
                    chk(bus.out_data[h], e, $sformatf("sb_data_h%0d", h));
                end
                got[h].push_back(bus.out_data[h]);
            end
            if (bus.in_valid[h] && bus.in_ready[h]) begin
                expq[h].push_back(model_beat(bus.in_data[h]));
                acc_cnt[h]++;
            end
        end
        if (lut_wen) begin
            if (lut_sel) m_lo[lut_waddr] = int'(lut_wdata);
            else         m_hi[lut_waddr] = int'(lut_wdata);
        end
        @(negedge clk);
    endtask

    task automatic lut_wr(input logic sel, input int addr, input int data);
        lut_wen = 1'b1; lut_sel = sel; lut_waddr = 4'(addr); lut_wdata = 16'(data);
        cyc();
        lut_wen = 1'b0;
    endtask

    task automatic idle();
        bus.in_valid  = '0;
        bus.out_ready = '1;
    endtask

    task automatic drain();
        idle();
        repeat (8) cyc();
    endtask

    initial begin
        int nxt, a1, a5, g5;
        rstn = 1'b0; cfg_shift = '0; lut_wen = 1'b0; lut_sel = 1'b0;
        lut_waddr = '0; lut_wdata = '0;
        bus.in_data = '0; bus.in_valid = '0; bus.out_ready = '0;
`ifdef CONSMAX_SAT_CNT_EN
        sat_cnt_clr = 1'b0;
`endif
        for (int k = 0; k < 16; k++) begin m_hi[k] = 0; m_lo[k] = 0; end
        for (int h = 0; h < HNUM; h++) acc_cnt[h] = 0;
        repeat (2) @(negedge clk);

        // Reset state
        #1;
        chk(64'(bus.out_valid), 64'h0, "rst_out_valid");
        chk(bus.out_data[0], 64'h0, "rst_out_data0");
        chk(64'(bus.in_ready), 64'hFF, "rst_in_ready");
        @(negedge clk);
        rstn = 1'b1;
        idle();
        cyc();

        // Basic map: HI=1, LO[k]=k+1, shift 0
        for (int k = 0; k < 16; k++) lut_wr(1'b0, k, 1);
        for (int k = 0; k < 16; k++) lut_wr(1'b1, k, k + 1);
        for (int h = 0; h < HNUM; h++) got[h].delete();
        bus.in_data[0] = 64'h0706050403020100;
        bus.in_valid[0] = 1'b1;
        cyc();
        bus.in_valid[0] = 1'b0;
        chk(64'(bus.out_valid[0]), 64'h0, "lat_t1");
        cyc();
        chk(64'(bus.out_valid[0]), 64'h0, "lat_t2");
        cyc();
        chk(64'(bus.out_valid[0]), 64'h1, "lat_t3");
        chk(bus.out_data[0], 64'h0807060504030201, "basic_map");
        drain();

        // Backpressure on head 2
        got[2].delete();
        nxt = 0;
        bus.out_ready[2] = 1'b0;
        bus.in_valid[2] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_data[2] = {8{8'(nxt)}};
            #1;
            if (i >= 3) chk(64'(bus.in_ready[2]), 64'h0, $sformatf("bp_full_%0d", i));
            if (bus.in_ready[2]) nxt++;
            cyc();
        end
        bus.out_ready[2] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in_data[2] = {8{8'(nxt)}};
            #1;
            if (i == 0) chk(64'(bus.in_ready[2]), 64'h1, "bp_release");
            if (bus.in_ready[2]) nxt++;
            cyc();
        end
        drain();
        chk(64'(got[2].size()), 64'(nxt), "bp_count");
        chk(64'(nxt), 64'd9, "bp_accepted");
        for (int i = 0; i < got[2].size(); i++)
            chk(got[2][i], {8{8'(i + 1)}}, $sformatf("bp_order_%0d", i));

        // LUT race: rewrite LO[3] 4 -> 9 in the acceptance cycle
        lut_wr(1'b1, 3, 4);
        got[0].delete();
        bus.in_data[0] = {8{8'h03}};
        bus.in_valid[0] = 1'b1;
        lut_wen = 1'b1; lut_sel = 1'b1; lut_waddr = 4'd3; lut_wdata = 16'd9;
        cyc();
        lut_wen = 1'b0;
        cyc();
        drain();
        chk(64'(got[0].size()), 64'd2, "race_count");
        chk(got[0].size() > 0 ? got[0][0] : 64'hDEAD, {8{8'h04}}, "race_old");
        chk(got[0].size() > 1 ? got[0][1] : 64'hDEAD, {8{8'h09}}, "race_new");

        // Head isolation: head 1 stalled, head 5 streaming
        a1 = acc_cnt[1]; a5 = acc_cnt[5]; g5 = got[5].size();
        bus.out_ready[1] = 1'b0;
        bus.in_valid[1] = 1'b1;
        bus.in_valid[5] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.in_data[1] = {$urandom, $urandom};
            bus.in_data[5] = {$urandom, $urandom};
            cyc();
        end
        chk(64'(acc_cnt[5] - a5), 64'd20, "iso_h5_accept");
        chk(64'(got[5].size() - g5), 64'd17, "iso_h5_output");
        chk(64'(acc_cnt[1] - a1), 64'd3, "iso_h1_accept");
        drain();

        // Randomized rounds: random LUTs, shift, traffic and mid-stream writes
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 16; k++) lut_wr(1'b0, k, int'($urandom_range(0, 65535)));
            for (int k = 0; k < 16; k++) lut_wr(1'b1, k, int'($urandom_range(0, 65535)));
            cfg_shift = (r == 0) ? 5'($urandom_range(14, 22)) : 5'($urandom_range(0, 31));
            for (int c = 0; c < 250; c++) begin
                for (int h = 0; h < HNUM; h++) begin
                    bus.in_valid[h]  = ($urandom_range(0, 9) < 7);
                    bus.out_ready[h] = ($urandom_range(0, 9) < 7);
                    bus.in_data[h]   = {$urandom, $urandom};
                end
                lut_wen = ($urandom_range(0, 9) == 0);
                lut_sel = 1'($urandom_range(0, 1));
                lut_waddr = 4'($urandom_range(0, 15));
                lut_wdata = 16'($urandom_range(0, 65535));
                cyc();
            end
            lut_wen = 1'b0;
            drain();
        end

        // Saturation: all entries 0x0100, shift 8 -> every byte 0xFF
        for (int k = 0; k < 16; k++) lut_wr(1'b0, k, 16'h0100);
        for (int k = 0; k < 16; k++) lut_wr(1'b1, k, 16'h0100);
        cfg_shift = 5'd8;
`ifdef CONSMAX_SAT_CNT_EN
        sat_cnt_clr = 1'b1;
        cyc();
        sat_cnt_clr = 1'b0;
`endif
        got[3].delete();
        bus.in_valid[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_data[3] = {$urandom, $urandom};
            cyc();
        end
        drain();
        chk(64'(got[3].size()), 64'd4, "sat_count");
        for (int i = 0; i < got[3].size(); i++)
            chk(got[3][i], 64'hFFFF_FFFF_FFFF_FFFF, $sformatf("sat_byte_%0d", i));
`ifdef CONSMAX_SAT_CNT_EN
        chk(64'(sat_cnt[3]), 64'd32, "sat_cnt_h3");
        sat_cnt_clr = 1'b1;
        cyc();
        sat_cnt_clr = 1'b0;
        chk(64'(sat_cnt[3]), 64'd0, "sat_cnt_clr");
`endif

        // Reset mid-stream with 3 beats parked in head 0
        bus.out_ready[0] = 1'b0;
        bus.in_valid[0] = 1'b1;
        repeat (3) begin
            bus.in_data[0] = {$urandom, $urandom};
            cyc();
        end
        bus.in_valid[0] = 1'b0;
        chk(64'(bus.out_valid[0]), 64'h1, "mid_full");
        rstn = 1'b0;
        #1;
        chk(64'(bus.out_valid), 64'h0, "mid_rst_valid");
        chk(bus.out_data[0], 64'h0, "mid_rst_data");
        for (int h = 0; h < HNUM; h++) expq[h].delete();
        for (int k = 0; k < 16; k++) begin m_hi[k] = 0; m_lo[k] = 0; end
        cyc();
        rstn = 1'b1;
        cyc();
        chk(64'(bus.out_valid), 64'h0, "mid_no_glitch");
        got[0].delete();
        idle();
        bus.in_data[0] = 64'hA5A5_5A5A_F00F_7E81;
        bus.in_valid[0] = 1'b1;
        cyc();
        drain();
        chk(64'(got[0].size()), 64'd1, "mid_post_count");
        chk(got[0].size() > 0 ? got[0][0] : 64'hDEAD, 64'h0, "mid_post_zero");

        for (int h = 0; h < HNUM; h++)
            chk(64'(expq[h].size()), 64'd0, $sformatf("sb_empty_h%0d", h));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/consmax_array.md
# consmax_array

Multi-head ConSmax nonlinear unit that replaces the single-stream softmax path beside the core array. Each of HNUM heads carries a GBUS_DATA-wide beat of signed 8-bit scores. Every byte is mapped through a split exponent LUT, exp(x) = LUT_HI[x[7:4]] * LUT_LO[x[3:0]], then right-shifted and saturated to 8 bits. Heads have independent 3-stage pipelines with valid/ready backpressure and share one runtime-programmable LUT pair.

## Interface
Parameters:
- HNUM, 8, number of heads (independent lanes)
- GBUS_DATA, 64, bits per head beat; multiple of 8; BYTES = GBUS_DATA/8
- LUT_ADDR, 4, LUT index width (half of the 8-bit input)
- LUT_DATA, 16, unsigned LUT entry width
- SHIFT_BIT, 5, width of cfg_shift

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset (decided: one clock, async active-low reset)
- cfg_shift  in  SHIFT_BIT  product right-shift; static while any beat is in flight
- lut_wen  in  1  LUT write strobe
- lut_sel  in  1  0 = LUT_HI, 1 = LUT_LO
- lut_waddr  in  LUT_ADDR  LUT entry index
- lut_wdata  in  LUT_DATA  entry value
- in_data  in  HNUM*GBUS_DATA  per-head input beats, head h at [h*GBUS_DATA +: GBUS_DATA]
- in_valid  in  HNUM  per-head input valid
- in_ready  out  HNUM  per-head input ready
- out_data  out  HNUM*GBUS_DATA  per-head result beats, same packing as in_data
- out_valid  out  HNUM  per-head output valid
- out_ready  in  HNUM  per-head downstream ready
- sat_cnt  out  HNUM*16  per-head saturation counters (CONSMAX_SAT_CNT_EN only)
- sat_cnt_clr  in  1  synchronous clear of all counters (CONSMAX_SAT_CNT_EN only)

## Operation
- LUT: 2 x 2^LUT_ADDR flops of LUT_DATA bits. A write at cycle t is visible to lookups at cycle t+1 and later.
- Per byte x: hi = x[7:4] (raw nibble address), lo = x[3:0].
  - S0: register beat and both LUT reads.
  - S1: compute p = hi_val * lo_val (2*LUT_DATA bits, unsigned).
  - S2: compute q = p >> cfg_shift. Output byte = 8'hFF if q > 255, else q[7:0].
- Handshake per head: a beat transfers on valid & ready.
  - Each stage loads when it is empty or its content moves downstream (bubbles collapse).
  - in_ready[h] = !s0_valid | s0 moves. This path is combinational from out_ready[h].
- out_data/out_valid are the S2 registers. out_data holds stable while out_valid & !out_ready.
- Heads never interact. A stall on head h does not affect any other head.

## Timing
- Reset values: all pipeline valids 0; out_valid = 0; out_data = 0; all LUT entries 0; sat_cnt = 0. in_ready = all ones after reset.
- Latency: beat accepted at cycle t appears with out_valid at t+3 when out_ready is held high.
- Throughput: 1 beat/cycle/head.
- Full: with out_ready low, a head holds 3 beats. in_ready drops only once S0..S2 are all occupied.
- Release: out_ready rising with a full head gives in_ready = 1 in the same cycle.
- Simultaneous LUT write and lookup of the same entry: the lookup returns the old value.
- Reset mid-operation: in-flight beats are discarded, LUTs are cleared, and there is no output glitch after rstn deasserts.

## Configuration
- CONSMAX_SAT_CNT_EN defined:
  - Each output byte transferred with saturation increments sat_cnt[h]. A beat can add up to BYTES.
  - Counters stick at 16'hFFFF.
  - sat_cnt_clr zeroes all counters; clr in the same cycle as an increment wins.
- Undefined: sat_cnt and sat_cnt_clr ports are absent, with no saturation-tracking logic.

## Structure
- Package consmax_pkg: LUT_ADDR/LUT_DATA/SHIFT_BIT constants, lut_entry_t, product_t, head_beat_t typedefs.
- Sub-module consmax_head_pipe: one head's 3-stage pipeline, handshake and optional counter. Generated HNUM times.
- The top holds the shared LUTs, the write port and the fan-out of the LUT read buses.

## Test plan
- Basic map: LUT_HI all 1, LUT_LO[k] = k+1, shift 0; head 0 beat bytes 0x00..0x07 -> out bytes 1..8 at t+3.
- Saturation: all entries 0x0100, shift 8 -> every byte 0xFF. With CONSMAX_SAT_CNT_EN, sat_cnt[h] += BYTES per beat; clr -> 0.
- Backpressure: continuous input on head 2, out_ready low 5 cycles -> in_ready low after 3 beats, then in-order output with no loss or duplication.
- LUT race: write LUT_LO[3] 4 -> 9 at cycle t; beats with lo=3 accepted at t and t+1 -> outputs 4 and 9 (HI = 1, shift 0).
- Head isolation: head 1 stalled, head 5 streaming -> head 5 sustains 1 beat/cycle.
- Reset mid-stream: assert rstn low with 3 beats in flight -> out_valid 0, LUTs read 0, first post-reset beat yields 0.
